// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scan controller: per-digit slot with a blanking gap,
// leading-zero suppression and frame-aligned update of the displayed value.
module fnd_scan_controller #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_blank_lz,
    output logic [1:0]  o_digitSelect,
    output logic        o_en,
    output logic [3:0]  o_value,
    output logic        o_dp,
    output logic        o_pending
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;
    logic [15:0]      shadow_val, disp_val;
    logic [3:0]       shadow_dp, disp_dp;
    logic             pending;
    logic             slot_end, frame_end, copy;
    logic [3:0]       lz_blank;
    logic [1:0]       sel;
    logic             en_next;

    assign slot_end  = (state != ST_IDLE) && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    // A pending value is taken at the 3->0 boundary, or at once while idle.
    assign copy      = pending && ((state == ST_IDLE) || (i_en && frame_end));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_next   = '0;
        idx_next   = 2'd0;
        state_next = ST_IDLE;
        if (i_en) begin
            if (state != ST_IDLE) begin
                cnt_next = slot_end ? '0 : cnt + 1'b1;
                idx_next = slot_end ? idx + 2'd1 : idx;
            end
            // The state follows from the slot position, which also covers BLANK_CYC = 0.
            state_next = (int'(cnt_next) < BLANK_CYC) ? ST_BLANK : ST_SHOW;
        end
    end

    // Digit k is suppressed only when it and every higher digit are zero.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = i_blank_lz && (disp_val[15:12] == 4'd0);
        lz_blank[2] = lz_blank[3] && (disp_val[11:8] == 4'd0);
        lz_blank[1] = lz_blank[2] && (disp_val[7:4] == 4'd0);
    end

    assign sel     = i_en ? idx : 2'd0;
    assign en_next = i_en && (state == ST_SHOW) && !lz_blank[idx];

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= 2'd0;
            shadow_val    <= 16'h0000;
            shadow_dp     <= 4'h0;
            disp_val      <= 16'h0000;
            disp_dp       <= 4'h0;
            pending       <= 1'b0;
            o_digitSelect <= 2'd0;
            o_en          <= 1'b0;
            o_value       <= 4'd0;
            o_dp          <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;

            if (i_load) begin
                shadow_val <= i_value;
                shadow_dp  <= i_dp;
            end
            if (copy) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            // A load coinciding with the copy keeps the flag set for the new value.
            pending <= i_load || (pending && !copy);

            o_digitSelect <= sel;
            o_en          <= en_next;
            o_value       <= disp_val[{sel, 2'b00} +: 4];
            o_dp          <= disp_dp[sel];
        end
    end

    assign o_pending = pending;

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Time-multiplexed scan controller for the 4-digit FND (7-segment) display. It holds a 4-digit BCD word, cycles through the digits at a fixed refresh rate and drives the digit-select decoder (select code plus enable) and the BCD-to-FND font decoder (one BCD nibble). It inserts an inter-digit blanking gap against ghosting and applies new display values only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- CLK_DIV, default 100000: clock cycles per digit slot, ≥ 2 (1 kHz per digit at 100 MHz).
- BLANK_CYC, default 1000: cycles at the start of each slot with the display disabled, 0 ≤ BLANK_CYC < CLK_DIV.

Ports (clock is i_clk; reset is i_reset_n, asynchronous and active-low):
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_en  in  1  scan enable; 0 = display off.
- i_load  in  1  single-cycle strobe that captures i_value and i_dp.
- i_value  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- i_dp  in  4  decimal point per digit, captured with i_value.
- i_blank_lz  in  1  level signal that enables leading-zero blanking.
- o_digitSelect  out  2  digit index, 0 to 3, to the select decoder.
- o_en  out  1  select-decoder enable; 1 = drive the selected digit.
- o_value  out  4  BCD nibble of the current digit, to the font decoder.
- o_dp  out  1  decimal point of the current digit.
- o_pending  out  1  captured value is waiting for the next frame boundary.

## Operation
- Registers:
  - Shadow register: 16 bits of value and 4 bits of dp, written on i_load.
  - Display register: the same 20 bits, feeding the outputs.
  - Prescaler cnt: $clog2(CLK_DIV) bits.
  - Digit index: 2 bits.
  - State.
- States:
  - IDLE: i_en=0.
  - BLANK: cnt < BLANK_CYC.
  - SHOW: the rest of the slot.
- Transitions:
  - IDLE → BLANK on i_en=1, or straight to SHOW when BLANK_CYC=0.
  - BLANK → SHOW when cnt reaches BLANK_CYC.
  - SHOW → BLANK (or SHOW) at the slot end, when cnt = CLK_DIV-1. cnt wraps to 0 and the digit index increments mod 4 (3 → 0).
  - Any state → IDLE on i_en=0, on the next edge. In IDLE, cnt=0, digit index=0 and o_en=0.
- Output path:
  - o_digitSelect = digit index.
  - o_value = display nibble of that digit.
  - o_dp = dp bit of that digit.
- o_en is 1 only in SHOW, and only if the digit is not blanked.
- Leading-zero blanking (i_blank_lz=1):
  - Digit k (k = 3, 2, 1) is blanked when its display nibble is 0 and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - The dp bit does not prevent blanking.
- Nibbles above 9 are passed through unchanged; the font decoder shows them as hex.
- Load handshake:
  - i_load writes the shadow register and sets o_pending.
  - The shadow register is copied to the display register at the frame boundary (digit 3 slot end, index 3 → 0). o_pending clears in the same cycle.
  - In IDLE, a pending value is copied on the next edge.
  - A second i_load while o_pending=1 overwrites the shadow register; only the last value is shown.
  - An i_load in the same cycle as the boundary copy is not lost: the old shadow value is copied, the new one is captured and o_pending stays 1.

## Timing
- Reset (asynchronous, takes effect immediately):
  - o_digitSelect=0, o_en=0, o_value=0, o_dp=0, o_pending=0.
  - Shadow and display registers are 0; cnt=0; state IDLE.
- Deasserting i_reset_n mid-scan aborts the scan. The first slot after reset starts at digit 0.
- All outputs are registered and change one cycle after the state or cnt edge that causes them.
- Slot length is exactly CLK_DIV cycles:
  - o_en is low for the first BLANK_CYC cycles of the slot.
  - o_en is high (unless blanked) for the remaining CLK_DIV-BLANK_CYC cycles.
- Frame length = 4·CLK_DIV cycles.
- Load-to-display latency is at most one frame plus one cycle.
- o_en goes low within one cycle of i_en falling.

## Test plan
Use CLK_DIV=8, BLANK_CYC=2.
- Reset, then i_en=1, i_load with i_value=16'h1234 and i_dp=0 → o_digitSelect steps 0,1,2,3,0 every 8 cycles; o_value=4,3,2,1; o_en low 2 cycles and high 6 cycles per slot.
- Load 16'h5678 during the digit-1 slot → o_pending=1 until the 3→0 boundary; digits 1–3 of that frame still show 3,2,1; the next frame shows 8,7,6,5 and o_pending=0.
- i_blank_lz=1, value 16'h0040 → o_en stays 0 in the slots for digits 3 and 2; digit 1 shows 4 and digit 0 shows 0. Value 16'h0000 → only digit 0 is enabled, showing 0.
- Two i_load strobes (16'hAAAA, then 16'h9999) inside one frame, and a separate i_load on the exact boundary cycle → the next frame shows 9999; the boundary-cycle value appears one frame later.
- i_en dropped mid-slot → o_en=0 on the next cycle and o_digitSelect=0. i_en raised again → the scan restarts at digit 0 with a fresh 2-cycle blank.
- i_reset_n pulsed low mid-SHOW → all outputs are 0 immediately, and the display register is cleared to 16'h0000.
